// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types and note table for the buzzer voice arbiter
package tone_pkg;

    localparam int CNT_W      = 19;
    localparam int NUM_VOICES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    // Half-period counts at 50 MHz: open low E, 3rd, 5th and 6th fret.
    localparam logic [CNT_W-1:0] HALF_TABLE [NUM_VOICES] = '{
        19'd303361, 19'd255095, 19'd227264, 19'd214509
    };

endpackage

// File: rtl/tone_voice_arbiter_if.sv
// rtl/tone_voice_arbiter_if.sv - button and buzzer signals of the voice arbiter
interface tone_voice_arbiter_if;

    logic [3:0] btn_n;
    logic       buzzer;
    logic [1:0] voice;
    logic       voice_valid;

    modport master (output btn_n, input buzzer, input voice, input voice_valid);
    modport slave  (input btn_n, output buzzer, output voice, output voice_valid);

endinterface

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - shared square-wave generator, period 2*(half+1) cycles
module tone_gen
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] half,
    output logic             wave
);

    logic [CNT_W-1:0] cnt;

    // Disabling parks the counter and output so every note starts low at count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt >= half) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tone_voice_arbiter.sv
// rtl/tone_voice_arbiter.sv - debounced last-pressed-wins voice arbiter driving one buzzer
module tone_voice_arbiter
    import tone_pkg::*;
#(
    parameter int               DEBOUNCE_CYC = 1_000_000,
    parameter int               GAP_CYC      = 100_000,
    parameter logic [CNT_W-1:0] HALF_0       = HALF_TABLE[0],
    parameter logic [CNT_W-1:0] HALF_1       = HALF_TABLE[1],
    parameter logic [CNT_W-1:0] HALF_2       = HALF_TABLE[2],
    parameter logic [CNT_W-1:0] HALF_3       = HALF_TABLE[3]
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tone_voice_arbiter_if.slave  bus
);

    localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    logic [3:0]       sync1, sync2;
    logic [3:0]       db_level;
    logic [3:0]       press;
    logic [3:0]       held;
    logic [1:0]       recent;
    logic [1:0]       target;
    logic             target_ok;
    state_t           state, state_d;
    logic [1:0]       voice_q, voice_d;
    logic [GAP_W-1:0] gap_cnt, gap_d;
    logic             tone_en;
    logic [CNT_W-1:0] half_sel;
    logic             wave;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= bus.btn_n;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                level <= 1'b1;
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt   <= '0;
                level <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign db_level[i] = level;
        assign press[i]    = ~sync2[i] & level & (cnt == DB_LAST);
    end

    assign held = ~db_level;

    // Simultaneous presses resolve to the higher index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recent <= 2'd0;
        end else if (press[3]) begin
            recent <= 2'd3;
        end else if (press[2]) begin
            recent <= 2'd2;
        end else if (press[1]) begin
            recent <= 2'd1;
        end else if (press[0]) begin
            recent <= 2'd0;
        end
    end

    always_comb begin
        target    = recent;
        target_ok = |held;
        if (!held[recent]) begin
            target = 2'd0;
            for (int i = 3; i >= 0; i--) begin
                if (held[i]) target = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            voice_q <= 2'd0;
            gap_cnt <= '0;
        end else begin
            state   <= state_d;
            voice_q <= voice_d;
            gap_cnt <= gap_d;
        end
    end

    // The tone is enabled only while staying in PLAY, so leaving PLAY silences it on the same edge.
    always_comb begin
        state_d = state;
        voice_d = voice_q;
        gap_d   = gap_cnt;
        tone_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (target_ok) begin
                    state_d = ST_GAP;
                    voice_d = target;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (!target_ok) begin
                    state_d = ST_IDLE;
                end else if (target != voice_q) begin
                    voice_d = target;
                    gap_d   = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    state_d = ST_PLAY;
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            ST_PLAY: begin
                if (!target_ok) begin
                    state_d = ST_IDLE;
                end else if (target != voice_q) begin
                    state_d = ST_GAP;
                    voice_d = target;
                    gap_d   = '0;
                end else begin
                    tone_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        half_sel = HALF_0;
        case (voice_q)
            2'd0:    half_sel = HALF_0;
            2'd1:    half_sel = HALF_1;
            2'd2:    half_sel = HALF_2;
            default: half_sel = HALF_3;
        endcase
    end

    tone_gen u_tone_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tone_en),
        .half  (half_sel),
        .wave  (wave)
    );

    assign bus.buzzer      = wave;
    assign bus.voice       = voice_q;
    assign bus.voice_valid = (state == ST_PLAY);

endmodule

// File: tb/tb_tone_voice_arbiter.sv
// tb/tb_tone_voice_arbiter.sv - scoreboard bench for the buzzer voice arbiter
module tb_tone_voice_arbiter;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    typedef struct {
        int btn;
        int hold;
        bit sounds;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   cur_voice = 0;
    logic [3:0] prev_s = 4'b0000;
    ev_t  exp_q[$];
    vec_t vecs[7];

    tone_voice_arbiter_if bus ();

    tone_voice_arbiter #(
        .DEBOUNCE_CYC (8),
        .GAP_CYC      (4),
        .HALF_0       (19'd3),
        .HALF_1       (19'd4),
        .HALF_2       (19'd5),
        .HALF_3       (19'd6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int half_of(input int v);
        case (v)
            0:       return 3;
            1:       return 4;
            2:       return 5;
            default: return 6;
        endcase
    endfunction

    task automatic push_ev(input int c, input logic vv, input int v, input logic bz);
        ev_t e;
        e.cyc = c;
        e.val = {vv, 2'(v), bz};
        exp_q.push_back(e);
    endtask

    // A note: valid from start, buzzer toggling every half+1 cycles until the edge that leaves PLAY.
    task automatic exp_play(input int v, input int start, input int stop);
        logic b;
        b = 1'b0;
        push_ev(start, 1'b1, v, 1'b0);
        for (int t = start + half_of(v) + 1; t < stop; t += half_of(v) + 1) begin
            b = ~b;
            push_ev(t, 1'b1, v, b);
        end
    endtask

    task automatic tick();
        logic [3:0] now_s;
        ev_t e;
        @(negedge clk);
        now_s = {bus.voice_valid, bus.voice, bus.buzzer};
        if (now_s !== prev_s) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d got=%b required=no_change", cyc, now_s);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val !== now_s) begin
                    failures++;
                    $display("FAIL event got cyc=%0d val=%b required cyc=%0d val=%b", cyc, now_s, e.cyc, e.val);
                end
            end
            prev_s = now_s;
        end
    endtask

    task automatic drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_events got=%0d required=0 next_cyc=%0d", name, exp_q.size(), exp_q[0].cyc);
        end
        exp_q.delete();
    endtask

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    initial begin
        int k, s, r, r2, q;
        vecs[0] = '{btn: 0, hold: 40, sounds: 1'b1};
        vecs[1] = '{btn: 1, hold: 33, sounds: 1'b1};
        vecs[2] = '{btn: 2, hold: 45, sounds: 1'b1};
        vecs[3] = '{btn: 3, hold: 50, sounds: 1'b1};
        vecs[4] = '{btn: 2, hold: 3,  sounds: 1'b0};
        vecs[5] = '{btn: 1, hold: 7,  sounds: 1'b0};
        vecs[6] = '{btn: 0, hold: 8,  sounds: 1'b1};

        rst_n = 1'b0;
        bus.btn_n = 4'hF;
        #1;
        check_val("reset_outputs", {bus.voice_valid, bus.voice, bus.buzzer}, 4'b0000);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        drained("idle_quiet");

        for (int i = 0; i < 7; i++) begin
            k = cyc;
            if (vecs[i].sounds) begin
                if (vecs[i].btn != cur_voice) push_ev(k + 11, 1'b0, vecs[i].btn, 1'b0);
                exp_play(vecs[i].btn, k + 15, k + vecs[i].hold + 11);
                push_ev(k + vecs[i].hold + 11, 1'b0, vecs[i].btn, 1'b0);
                cur_voice = vecs[i].btn;
            end
            bus.btn_n[vecs[i].btn] = 1'b0;
            repeat (vecs[i].hold) tick();
            bus.btn_n[vecs[i].btn] = 1'b1;
            repeat (25) tick();
            drained($sformatf("vec%0d", i));
        end

        // Hold voice 0, interrupt with voice 3, then fall back to voice 0.
        k  = cyc;
        s  = k + 30;
        r  = s + 40;
        r2 = r + 40;
        if (cur_voice != 0) push_ev(k + 11, 1'b0, 0, 1'b0);
        exp_play(0, k + 15, s + 11);
        push_ev(s + 11, 1'b0, 3, 1'b0);
        exp_play(3, s + 15, r + 11);
        push_ev(r + 11, 1'b0, 0, 1'b0);
        exp_play(0, r + 15, r2 + 11);
        push_ev(r2 + 11, 1'b0, 0, 1'b0);
        cur_voice = 0;
        bus.btn_n[0] = 1'b0;
        repeat (30) tick();
        bus.btn_n[3] = 1'b0;
        repeat (40) tick();
        bus.btn_n[3] = 1'b1;
        repeat (40) tick();
        bus.btn_n[0] = 1'b1;
        repeat (25) tick();
        drained("override_fallback");

        // Buttons 1 and 2 accepted on the same edge; higher index wins, then fallback to 1.
        k  = cyc;
        r  = k + 40;
        r2 = r + 40;
        push_ev(k + 11, 1'b0, 2, 1'b0);
        exp_play(2, k + 15, r + 11);
        push_ev(r + 11, 1'b0, 1, 1'b0);
        exp_play(1, r + 15, r2 + 11);
        push_ev(r2 + 11, 1'b0, 1, 1'b0);
        cur_voice = 1;
        bus.btn_n[2:1] = 2'b00;
        repeat (40) tick();
        bus.btn_n[2] = 1'b1;
        repeat (40) tick();
        bus.btn_n[1] = 1'b1;
        repeat (25) tick();
        drained("simultaneous_press");

        // Asynchronous reset while the buzzer is high, button kept held throughout.
        k = cyc;
        push_ev(k + 11, 1'b0, 0, 1'b0);
        exp_play(0, k + 15, k + 21);
        push_ev(k + 21, 1'b0, 0, 1'b0);
        bus.btn_n[0] = 1'b0;
        repeat (20) tick();
        check_val("pre_reset_buzzer", {3'b000, bus.buzzer}, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_outputs", {bus.voice_valid, bus.voice, bus.buzzer}, 4'b0000);
        repeat (3) tick();
        rst_n = 1'b1;
        cur_voice = 0;
        q = cyc;
        r = q + 30;
        exp_play(0, q + 15, r + 11);
        push_ev(r + 11, 1'b0, 0, 1'b0);
        repeat (30) tick();
        bus.btn_n[0] = 1'b1;
        repeat (25) tick();
        drained("reset_mid_note");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
